hdmux2_rr_stage: RTL and testbench

- Registered two-source round-robin arbitration stage for the HD standard-cell mux datapath in the xsim cell models.
- Sits directly upstream of the HDMUX2-family 2:1 mux. Generates its select (SL) and feeds it a registered, handshaked output word.
- Arbitrates two valid/ready sources A0 and A1 with lock (burst) support. Holds the winner in a single-entry output register.

---
 rtl/hdmux2_rr_stage_if.sv | 32 +++
 rtl/hdmux2_rr_stage.sv | 121 ++++++++++++
 tb/tb_hdmux2_rr_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmux2_rr_stage_if.sv
// Handshake bundle for hdmux2_rr_stage.
// Two valid/ready sources (A0/V0/LK0/R0 and A1/V1/LK1/R1) feed one registered
// output channel (Z/ZV/ZR). SL and LKD report arbiter status.
// master : the arbitration stage (drives R0, R1, Z, ZV, SL, LKD)
// slave  : the surrounding logic (drives source data/valid/lock and ZR)
interface hdmux2_rr_stage_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0] A0;
  logic         V0;
  logic         LK0;
  logic         R0;
  logic [W-1:0] A1;
  logic         V1;
  logic         LK1;
  logic         R1;
  logic [W-1:0] Z;
  logic         ZV;
  logic         ZR;
  logic         SL;
  logic         LKD;

  modport master (
    input  A0, V0, LK0, A1, V1, LK1, ZR,
    output R0, R1, Z, ZV, SL, LKD
  );

  modport slave (
    output A0, V0, LK0, A1, V1, LK1, ZR,
    input  R0, R1, Z, ZV, SL, LKD
  );
endinterface

// File: rtl/hdmux2_rr_stage.sv
// Registered two-source round-robin arbitration stage with lock (burst)
// support. The winning word is held in a single-entry output register; SL
// reports which source supplied the most recent accepted word.
// Ports:
//   CK  - clock, rising edge
//   RN  - synchronous active-low reset
//   bus - hdmux2_rr_stage_if master view (sources, output channel, status)
module hdmux2_rr_stage #(
  parameter int unsigned W = 1
) (
  input logic                CK,
  input logic                RN,
  hdmux2_rr_stage_if.master  bus
);

  typedef enum logic [1:0] {
    StArb   = 2'b00,
    StLock0 = 2'b01,
    StLock1 = 2'b10
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] z_q;
  logic         zv_q;
  logic         sl_q;
  logic         lkd_q;

  logic ld;
  logic g0, g1;
  logic r0, r1;
  logic t0, t1;

  // Output register can take a new word when empty or draining this cycle.
  assign ld = !zv_q || bus.ZR;

  assign r0 = RN && ld && g0;
  assign r1 = RN && ld && g1;
  assign t0 = bus.V0 && r0;
  assign t1 = bus.V1 && r1;

  // State register
  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= StArb;
      lkd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lkd_q   <= (state_d != StArb);
    end
  end

  // Next-state logic; only a source transfer can move the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StArb: begin
        if (t0 && bus.LK0) begin
          state_d = StLock0;
        end else if (t1 && bus.LK1) begin
          state_d = StLock1;
        end
      end
      StLock0: if (t0 && !bus.LK0) state_d = StArb;
      StLock1: if (t1 && !bus.LK1) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Grant logic; an illegal state grants nobody until it recovers.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (state_q)
      StArb: begin
        if (bus.V0 && bus.V1) begin
          // Tie: give it to the source that did not win last time.
          g0 = sl_q;
          g1 = !sl_q;
        end else begin
          g0 = bus.V0;
          g1 = bus.V1;
        end
      end
      StLock0: g0 = bus.V0;
      StLock1: g1 = bus.V1;
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
  end

  // Output register; grants are exclusive so t0/t1 never both fire.
  always_ff @(posedge CK) begin
    if (!RN) begin
      z_q  <= '0;
      zv_q <= 1'b0;
      sl_q <= 1'b0;
    end else if (ld) begin
      if (t0) begin
        z_q  <= bus.A0;
        zv_q <= 1'b1;
        sl_q <= 1'b0;
      end else if (t1) begin
        z_q  <= bus.A1;
        zv_q <= 1'b1;
        sl_q <= 1'b1;
      end else begin
        zv_q <= 1'b0;
      end
    end
  end

  assign bus.R0  = r0;
  assign bus.R1  = r1;
  assign bus.Z   = z_q;
  assign bus.ZV  = zv_q;
  assign bus.SL  = sl_q;
  assign bus.LKD = lkd_q;

endmodule

// File: tb/tb_hdmux2_rr_stage.sv
// Directed self-checking bench for hdmux2_rr_stage with W=4.
// Inputs are driven 1 time unit after a rising edge; combinational ready is
// checked 2 units later, registered outputs 1 unit after the following edge.
module tb_hdmux2_rr_stage;

  localparam int unsigned W = 4;

  logic CK;
  logic RN;
  int   n_checks;
  int   n_fail;

  hdmux2_rr_stage_if #(.W(W)) bus ();

  hdmux2_rr_stage #(.W(W)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Advance past the next rising edge.
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.A0  = '0;
    bus.V0  = 1'b0;
    bus.LK0 = 1'b0;
    bus.A1  = '0;
    bus.V1  = 1'b0;
    bus.LK1 = 1'b0;
    bus.ZR  = 1'b1;
  endtask

  task automatic test_reset();
    // Load a word of 5 while downstream stalls.
    idle_inputs();
    bus.A0 = 4'd5;
    bus.V0 = 1'b1;
    bus.ZR = 1'b0;
    step();
    n_checks++;
    if ({bus.Z, bus.ZV, bus.SL} !== {4'd5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_preload: got Z=%0d ZV=%b SL=%b, want Z=5 ZV=1 SL=0",
               bus.Z, bus.ZV, bus.SL);
    end
    // Reset with both sources valid and downstream ready: readies must stay 0.
    RN = 1'b0;
    bus.V0 = 1'b1;
    bus.V1 = 1'b1;
    bus.ZR = 1'b1;
    #2;
    n_checks++;
    if ({bus.R0, bus.R1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got R0=%b R1=%b, want 0 0", bus.R0, bus.R1);
    end
    step();
    n_checks++;
    if ({bus.Z, bus.ZV, bus.SL, bus.LKD} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got Z=%0d ZV=%b SL=%b LKD=%b, want 0 0 0 0",
               bus.Z, bus.ZV, bus.SL, bus.LKD);
    end
    idle_inputs();
    RN = 1'b1;
  endtask

  task automatic test_tie_alternate();
    logic [3:0] exp_z [4];
    logic       exp_sl [4];
    exp_z  = '{4'd9, 4'd3, 4'd9, 4'd3};
    exp_sl = '{1'b1, 1'b0, 1'b1, 1'b0};
    idle_inputs();
    bus.A0 = 4'd3;
    bus.A1 = 4'd9;
    bus.V0 = 1'b1;
    bus.V1 = 1'b1;
    #2;
    n_checks++;
    if ({bus.R0, bus.R1} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_first_grant: got R0=%b R1=%b, want 0 1", bus.R0, bus.R1);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({bus.Z, bus.ZV, bus.SL} !== {exp_z[i], 1'b1, exp_sl[i]}) begin
        n_fail++;
        $display("FAIL tie_beat%0d: got Z=%0d ZV=%b SL=%b, want Z=%0d ZV=1 SL=%b",
                 i, bus.Z, bus.ZV, bus.SL, exp_z[i], exp_sl[i]);
      end
    end
    idle_inputs();
    step();
    n_checks++;
    if (bus.ZV !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_drain: got ZV=%b, want 0", bus.ZV);
    end
  endtask

  task automatic test_single_source();
    idle_inputs();
    bus.V0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.A0 = 4'(k);
      #2;
      n_checks++;
      if ({bus.R0, bus.R1} !== 2'b10) begin
        n_fail++;
        $display("FAIL single_ready%0d: got R0=%b R1=%b, want 1 0", k, bus.R0, bus.R1);
      end
      step();
      n_checks++;
      if ({bus.Z, bus.ZV, bus.SL} !== {4'(k), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_beat%0d: got Z=%0d ZV=%b SL=%b, want Z=%0d ZV=1 SL=0",
                 k, bus.Z, bus.ZV, bus.SL, k);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.A0 = 4'd7;
    bus.V0 = 1'b1;
    bus.ZR = 1'b0;
    step();
    bus.V0 = 1'b0;
    bus.A0 = 4'd2;
    bus.A1 = 4'd4;
    bus.V1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++;
      if ({bus.R0, bus.R1} !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_ready%0d: got R0=%b R1=%b, want 0 0", c, bus.R0, bus.R1);
      end
      step();
      n_checks++;
      if ({bus.Z, bus.ZV, bus.SL} !== {4'd7, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got Z=%0d ZV=%b SL=%b, want Z=7 ZV=1 SL=0",
                 c, bus.Z, bus.ZV, bus.SL);
      end
    end
    bus.ZR = 1'b1;
    #2;
    n_checks++;
    if ({bus.R0, bus.R1} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release_ready: got R0=%b R1=%b, want 0 1", bus.R0, bus.R1);
    end
    step();
    n_checks++;
    if ({bus.Z, bus.ZV, bus.SL} !== {4'd4, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_release: got Z=%0d ZV=%b SL=%b, want Z=4 ZV=1 SL=1",
               bus.Z, bus.ZV, bus.SL);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_lock();
    logic [3:0] data [4];
    logic       exp_lkd [4];
    data    = '{4'hA, 4'hB, 4'hC, 4'hD};
    exp_lkd = '{1'b1, 1'b1, 1'b1, 1'b0};
    // SL=1 from the previous test, so the first tie goes to A0.
    idle_inputs();
    bus.V0 = 1'b1;
    bus.V1 = 1'b1;
    bus.A1 = 4'd6;
    for (int b = 0; b < 4; b++) begin
      bus.A0  = data[b];
      bus.LK0 = (b < 3);
      #2;
      n_checks++;
      if ({bus.R0, bus.R1} !== 2'b10) begin
        n_fail++;
        $display("FAIL lock_ready%0d: got R0=%b R1=%b, want 1 0", b, bus.R0, bus.R1);
      end
      step();
      n_checks++;
      if ({bus.Z, bus.ZV, bus.SL, bus.LKD} !== {data[b], 1'b1, 1'b0, exp_lkd[b]}) begin
        n_fail++;
        $display("FAIL lock_beat%0d: got Z=%0d ZV=%b SL=%b LKD=%b, want Z=%0d ZV=1 SL=0 LKD=%b",
                 b, bus.Z, bus.ZV, bus.SL, bus.LKD, data[b], exp_lkd[b]);
      end
    end
    bus.LK0 = 1'b0;
    #2;
    n_checks++;
    if ({bus.R0, bus.R1} !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_after_grant: got R0=%b R1=%b, want 0 1", bus.R0, bus.R1);
    end
    step();
    n_checks++;
    if ({bus.Z, bus.SL, bus.LKD} !== {4'd6, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_after_beat: got Z=%0d SL=%b LKD=%b, want Z=6 SL=1 LKD=0",
               bus.Z, bus.SL, bus.LKD);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_in_lock();
    idle_inputs();
    bus.A1  = 4'd8;
    bus.V1  = 1'b1;
    bus.LK1 = 1'b1;
    step();
    n_checks++;
    if ({bus.SL, bus.LKD} !== 2'b11) begin
      n_fail++;
      $display("FAIL lock1_enter: got SL=%b LKD=%b, want 1 1", bus.SL, bus.LKD);
    end
    RN = 1'b0;
    #2;
    n_checks++;
    if (bus.R1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lock1_reset_ready: got R1=%b, want 0", bus.R1);
    end
    step();
    n_checks++;
    if ({bus.ZV, bus.SL, bus.LKD} !== 3'b000) begin
      n_fail++;
      $display("FAIL lock1_reset_state: got ZV=%b SL=%b LKD=%b, want 0 0 0",
               bus.ZV, bus.SL, bus.LKD);
    end
    RN      = 1'b1;
    bus.A0  = 4'd1;
    bus.A1  = 4'd14;
    bus.V0  = 1'b1;
    bus.LK1 = 1'b0;
    #2;
    n_checks++;
    if ({bus.R0, bus.R1} !== 2'b01) begin
      n_fail++;
      $display("FAIL post_reset_tie: got R0=%b R1=%b, want 0 1", bus.R0, bus.R1);
    end
    step();
    n_checks++;
    if ({bus.Z, bus.ZV, bus.SL, bus.LKD} !== {4'd14, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_beat: got Z=%0d ZV=%b SL=%b LKD=%b, want Z=14 ZV=1 SL=1 LKD=0",
               bus.Z, bus.ZV, bus.SL, bus.LKD);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    RN = 1'b0;
    step();
    step();
    RN = 1'b1;
    test_reset();
    test_tie_alternate();
    test_single_source();
    test_backpressure();
    test_lock();
    test_reset_in_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
